dispatch_scheduler: RTL and testbench

- Sits between the instruction queue output and the back end: ALU reservation station, load/store buffer and reorder buffer.
- Holds one decoded instruction, classifies it by op, and checks per-unit free-slot credits and ROB credits.
- Issues to exactly one unit with a ROB tag. Otherwise it back-pressures the queue through in_ready / rs_full / rob_full.
- Handles pipeline flush and serializing (system) instructions.

---
 rtl/dispatch_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_dispatch_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_scheduler.sv
// Dispatch scheduler: holds one decoded instruction, classifies it and issues it
// to the ALU RS, load/store buffer or as a serializing op once credits allow.
module dispatch_scheduler #(
    parameter int unsigned RS_DEPTH  = 8,
    parameter int unsigned LSB_DEPTH = 8,
    parameter int unsigned ROB_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   in_op,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [4:0]                   in_rd,
    input  logic [31:0]                  in_imm,
    input  logic                         in_has_imm,
    output logic                         in_ready,
    output logic                         rs_full,
    output logic                         rob_full,
    input  logic                         rs_release,
    input  logic                         lsb_release,
    input  logic                         rob_commit,
    input  logic                         flush,
    output logic                         issue_valid,
    output logic [2:0]                   issue_unit,
    output logic [4:0]                   issue_op,
    output logic [4:0]                   issue_rs1,
    output logic [4:0]                   issue_rs2,
    output logic [4:0]                   issue_rd,
    output logic [31:0]                  issue_imm,
    output logic                         issue_has_imm,
    output logic [$clog2(ROB_DEPTH)-1:0] issue_tag
);

    localparam int unsigned TAG_W = $clog2(ROB_DEPTH);
    localparam int unsigned RS_W  = $clog2(RS_DEPTH + 1);
    localparam int unsigned LSB_W = $clog2(LSB_DEPTH + 1);
    localparam int unsigned ROB_W = $clog2(ROB_DEPTH + 1);

    localparam logic [4:0] OP_BUBBLE = 5'h1F;
    localparam logic [2:0] UNIT_ALU  = 3'b001;
    localparam logic [2:0] UNIT_LSB  = 3'b010;
    localparam logic [2:0] UNIT_SYS  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_STALL  = 2'd2,
        ST_SERIAL = 2'd3
    } state_t;

    state_t state, state_next;

    logic [2:0]       held_unit;
    logic [4:0]       held_op, held_rs1, held_rs2, held_rd;
    logic [31:0]      held_imm;
    logic             held_has_imm;

    logic [RS_W-1:0]  rs_cnt, rs_tmp, rs_next;
    logic [LSB_W-1:0] lsb_cnt, lsb_tmp, lsb_next;
    logic [ROB_W-1:0] rob_cnt, rob_tmp, rob_next;
    logic [TAG_W-1:0] tag, tag_next;

    logic held_c, can_issue_c, fire_c, capture_c;

    // Op decode: 0..19 ALU, 20..27 load/store, 28..31 serializing
    function automatic logic [2:0] classify(input logic [4:0] op);
        if (op < 5'd20)      return UNIT_ALU;
        else if (op < 5'd28) return UNIT_LSB;
        else                 return UNIT_SYS;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Issue decision, accept handshake and next state
    always_comb begin
        state_next  = state;
        can_issue_c = 1'b0;
        held_c      = (state != ST_IDLE);

        if (held_unit[0])
            can_issue_c = (rs_cnt != '0) && (rob_cnt != '0);
        else if (held_unit[1])
            can_issue_c = (lsb_cnt != '0) && (rob_cnt != '0);
        else
            can_issue_c = (rs_cnt != '0) && (rob_cnt == ROB_W'(ROB_DEPTH));

        fire_c    = held_c && can_issue_c && !flush;
        in_ready  = !held_c || fire_c;
        capture_c = in_ready && (in_op != OP_BUBBLE) && !flush;

        case (state)
            ST_IDLE: begin
                if (capture_c) state_next = ST_HELD;
            end
            default: begin
                if (fire_c)
                    state_next = capture_c ? ST_HELD : ST_IDLE;
                else
                    state_next = held_unit[2] ? ST_SERIAL : ST_STALL;
            end
        endcase

        if (flush) state_next = ST_IDLE;
    end

    // Credit and tag bookkeeping; a release at full credit is dropped
    always_comb begin
        rs_tmp   = rs_cnt - RS_W'(fire_c && !held_unit[1]);
        rs_next  = rs_tmp + RS_W'(rs_release && (rs_tmp != RS_W'(RS_DEPTH)));
        lsb_tmp  = lsb_cnt - LSB_W'(fire_c && held_unit[1]);
        lsb_next = lsb_tmp + LSB_W'(lsb_release && (lsb_tmp != LSB_W'(LSB_DEPTH)));
        rob_tmp  = rob_cnt - ROB_W'(fire_c);
        rob_next = rob_tmp + ROB_W'(rob_commit && (rob_tmp != ROB_W'(ROB_DEPTH)));
        tag_next = tag;
        if (fire_c)
            tag_next = (tag == TAG_W'(ROB_DEPTH - 1)) ? '0 : tag + TAG_W'(1);

        if (flush) begin
            rs_next  = RS_W'(RS_DEPTH);
            lsb_next = LSB_W'(LSB_DEPTH);
            rob_next = ROB_W'(ROB_DEPTH);
            tag_next = '0;
        end
    end

    // Hold register, credits and registered issue outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            held_unit     <= UNIT_ALU;
            held_op       <= OP_BUBBLE;
            held_rs1      <= '0;
            held_rs2      <= '0;
            held_rd       <= '0;
            held_imm      <= '0;
            held_has_imm  <= 1'b0;
            rs_cnt        <= RS_W'(RS_DEPTH);
            lsb_cnt       <= LSB_W'(LSB_DEPTH);
            rob_cnt       <= ROB_W'(ROB_DEPTH);
            tag           <= '0;
            rs_full       <= 1'b0;
            rob_full      <= 1'b0;
            issue_valid   <= 1'b0;
            issue_unit    <= 3'b000;
            issue_op      <= OP_BUBBLE;
            issue_rs1     <= '0;
            issue_rs2     <= '0;
            issue_rd      <= '0;
            issue_imm     <= '0;
            issue_has_imm <= 1'b0;
            issue_tag     <= '0;
        end else begin
            rs_cnt      <= rs_next;
            lsb_cnt     <= lsb_next;
            rob_cnt     <= rob_next;
            tag         <= tag_next;
            rs_full     <= (rs_next == '0);
            rob_full    <= (rob_next == '0);
            issue_valid <= fire_c;
            issue_unit  <= fire_c ? held_unit : 3'b000;

            if (fire_c) begin
                issue_op      <= held_op;
                issue_rs1     <= held_rs1;
                issue_rs2     <= held_rs2;
                issue_rd      <= held_rd;
                issue_imm     <= held_imm;
                issue_has_imm <= held_has_imm;
                issue_tag     <= tag;
            end

            if (capture_c) begin
                held_unit    <= classify(in_op);
                held_op      <= in_op;
                held_rs1     <= in_rs1;
                held_rs2     <= in_rs2;
                held_rd      <= in_rd;
                held_imm     <= in_imm;
                held_has_imm <= in_has_imm;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Randomized, model-checked bench for dispatch_scheduler.
module tb_dispatch_scheduler;

    localparam int RS_D  = 8;
    localparam int LSB_D = 8;
    localparam int ROB_D = 16;

    logic        clk;
    logic        rst;
    logic [4:0]  in_op, in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;
    logic        in_has_imm;
    logic        in_ready, rs_full, rob_full;
    logic        rs_release, lsb_release, rob_commit, flush;
    logic        issue_valid;
    logic [2:0]  issue_unit;
    logic [4:0]  issue_op, issue_rs1, issue_rs2, issue_rd;
    logic [31:0] issue_imm;
    logic        issue_has_imm;
    logic [3:0]  issue_tag;

    dispatch_scheduler #(.RS_DEPTH(RS_D), .LSB_DEPTH(LSB_D), .ROB_DEPTH(ROB_D)) dut (
        .clk(clk), .rst(rst),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_has_imm(in_has_imm),
        .in_ready(in_ready), .rs_full(rs_full), .rob_full(rob_full),
        .rs_release(rs_release), .lsb_release(lsb_release),
        .rob_commit(rob_commit), .flush(flush),
        .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_op(issue_op), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_imm(issue_imm),
        .issue_has_imm(issue_has_imm), .issue_tag(issue_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: credits as plain integers, at most one waiting instruction
    int          m_rs, m_lsb, m_rob, m_tag;
    bit          m_held;
    logic [4:0]  m_op, m_rs1, m_rs2, m_rd;
    logic [31:0] m_imm;
    logic        m_hi;

    logic        e_ready, e_valid, e_rs_full, e_rob_full, e_hi;
    logic [2:0]  e_unit;
    logic [4:0]  e_op, e_rs1, e_rs2, e_rd;
    logic [31:0] e_imm;
    logic [3:0]  e_tag;
    logic        obs_ready;

    function automatic logic [2:0] unit_of(input logic [4:0] op);
        if (op <= 5'd19) return 3'b001;
        if (op <= 5'd27) return 3'b010;
        return 3'b100;
    endfunction

    function automatic void model_reset();
        m_rs = RS_D; m_lsb = LSB_D; m_rob = ROB_D; m_tag = 0; m_held = 0;
        e_valid = 0; e_unit = 3'b000; e_rs_full = 0; e_rob_full = 0;
    endfunction

    function automatic void model_step(input bit r, input bit rr, input bit lr,
                                       input bit rc, input bit fl);
        logic [2:0] u;
        bit can;
        if (!r) begin
            model_reset();
            e_ready = 1'b1;
            return;
        end
        u = unit_of(m_op);
        can = 0;
        if (m_held && !fl) begin
            if (u == 3'b001)      can = (m_rs > 0) && (m_rob > 0);
            else if (u == 3'b010) can = (m_lsb > 0) && (m_rob > 0);
            else                  can = (m_rob == ROB_D) && (m_rs > 0);
        end
        e_ready = !m_held || can;
        if (fl) begin
            model_reset();
            return;
        end
        e_valid = can;
        e_unit  = can ? u : 3'b000;
        if (can) begin
            e_op = m_op; e_rs1 = m_rs1; e_rs2 = m_rs2; e_rd = m_rd;
            e_imm = m_imm; e_hi = m_hi; e_tag = 4'(m_tag);
            m_tag = (m_tag + 1) % ROB_D;
            m_rob = m_rob - 1;
            if (u == 3'b010) m_lsb = m_lsb - 1;
            else             m_rs  = m_rs - 1;
        end
        if (rr && m_rs  < RS_D)  m_rs  = m_rs + 1;
        if (lr && m_lsb < LSB_D) m_lsb = m_lsb + 1;
        if (rc && m_rob < ROB_D) m_rob = m_rob + 1;
        if (e_ready && in_op != 5'd31) begin
            m_held = 1; m_op = in_op; m_rs1 = in_rs1; m_rs2 = in_rs2;
            m_rd = in_rd; m_imm = in_imm; m_hi = in_has_imm;
        end else if (can) begin
            m_held = 0;
        end
        e_rs_full  = (m_rs == 0);
        e_rob_full = (m_rob == 0);
    endfunction

    // One clock: drive inputs, sample in_ready mid-cycle, advance the model, step past the edge
    task automatic tick(input bit r, input logic [4:0] op, input bit rr,
                        input bit lr, input bit rc, input bit fl);
        rst = r; in_op = op;
        in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_rd = 5'($urandom);
        in_imm = $urandom; in_has_imm = 1'($urandom);
        rs_release = rr; lsb_release = lr; rob_commit = rc; flush = fl;
        #1 obs_ready = in_ready;
        model_step(r, rr, lr, rc, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 5'd31, 0, 0, 0, 0);
        tick(1'b0, 5'd3, 1, 1, 1, 0);
        checks++;
        if ({issue_valid, issue_unit, issue_op, issue_rs1, issue_rs2, issue_rd,
             issue_imm, issue_has_imm, issue_tag, rs_full, rob_full} !==
            {1'b0, 3'b000, 5'd31, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b u=%b op=%0d tag=%0d rsf=%b robf=%b",
                     issue_valid, issue_unit, issue_op, issue_tag, rs_full, rob_full);
        end
        // instruction captured just before a reset must vanish
        tick(1'b1, 5'd5, 0, 0, 0, 0);
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", obs_ready);
        end
        tick(1'b0, 5'd31, 0, 0, 0, 0);
        tick(1'b1, 5'd31, 0, 0, 0, 0);
        checks++;
        if (issue_valid !== 1'b0 || obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard: got valid=%b ready=%b want 0/1", issue_valid, obs_ready);
        end
    endtask

    task automatic test_alu_burst();
        logic [4:0] ops [6];
        logic [11:0] tseq;
        int n;
        ops = '{5'd1, 5'd2, 5'd3, 5'd31, 5'd31, 5'd31};
        tseq = '0; n = 0;
        tick(1'b0, 5'd31, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, ops[i], 0, 0, 0, 0);
            checks++;
            if (obs_ready !== e_ready || {issue_valid, issue_unit, rs_full, rob_full} !==
                {e_valid, e_unit, e_rs_full, e_rob_full}) begin
                errors++;
                $display("FAIL alu_burst c%0d: got r=%b v=%b u=%b want r=%b v=%b u=%b", i,
                         obs_ready, issue_valid, issue_unit, e_ready, e_valid, e_unit);
            end
            if (issue_valid) begin
                n++; tseq = {tseq[7:0], issue_tag};
                if (i != n) begin
                    errors++; $display("FAIL alu_burst_timing: issue %0d at cycle %0d", n, i);
                end
                checks++;
            end
        end
        checks++;
        if (n != 3 || tseq !== 12'h012) begin
            errors++; $display("FAIL alu_burst_tags: got n=%0d seq=%h want 3/012", n, tseq);
        end
    endtask

    task automatic test_rs_full();
        int last_tag;
        last_tag = -1;
        tick(1'b0, 5'd31, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, (i < 9) ? 5'(i + 4) : 5'd31, (i == 12), 0, 0, 0);
            checks++;
            if (obs_ready !== e_ready || {issue_valid, issue_unit, rs_full, rob_full} !==
                {e_valid, e_unit, e_rs_full, e_rob_full}) begin
                errors++;
                $display("FAIL rs_full c%0d: got r=%b v=%b rsf=%b want r=%b v=%b rsf=%b", i,
                         obs_ready, issue_valid, rs_full, e_ready, e_valid, e_rs_full);
            end
            if (e_valid) begin
                checks++;
                if ({issue_op, issue_rs1, issue_rs2, issue_rd, issue_imm, issue_has_imm, issue_tag} !==
                    {e_op, e_rs1, e_rs2, e_rd, e_imm, e_hi, e_tag}) begin
                    errors++;
                    $display("FAIL rs_full_fields c%0d: got op=%0d tag=%0d want op=%0d tag=%0d",
                             i, issue_op, issue_tag, e_op, e_tag);
                end
            end
            if (issue_valid) last_tag = int'(issue_tag);
        end
        checks++;
        if (last_tag != 8) begin
            errors++; $display("FAIL rs_full_ninth_tag: got %0d want 8", last_tag);
        end
    endtask

    task automatic test_tag_wrap();
        int prev;
        bit wrapped, saw_full;
        prev = -1; wrapped = 0; saw_full = 0;
        tick(1'b0, 5'd31, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            tick(1'b1, 5'($urandom_range(0, 27)), 1, 1, (i >= 25) && 1'($urandom), 0);
            checks++;
            if (obs_ready !== e_ready || {issue_valid, issue_unit, rs_full, rob_full} !==
                {e_valid, e_unit, e_rs_full, e_rob_full}) begin
                errors++;
                $display("FAIL tag_wrap c%0d: got r=%b v=%b u=%b robf=%b want r=%b v=%b u=%b robf=%b",
                         i, obs_ready, issue_valid, issue_unit, rob_full,
                         e_ready, e_valid, e_unit, e_rob_full);
            end
            if (e_valid) begin
                checks++;
                if ({issue_op, issue_tag} !== {e_op, e_tag}) begin
                    errors++;
                    $display("FAIL tag_wrap_tag c%0d: got op=%0d tag=%0d want op=%0d tag=%0d",
                             i, issue_op, issue_tag, e_op, e_tag);
                end
            end
            if (rob_full) saw_full = 1;
            if (issue_valid) begin
                if (prev == 15 && issue_tag == 4'd0) wrapped = 1;
                prev = int'(issue_tag);
            end
        end
        checks++;
        if (!wrapped || !saw_full) begin
            errors++; $display("FAIL tag_wrap_seen: got wrap=%b full=%b want 1/1", wrapped, saw_full);
        end
    endtask

    task automatic test_lsb_release();
        int n;
        n = 0;
        tick(1'b0, 5'd31, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, (i < 11) ? 5'd20 + 5'(i % 8) : 5'd31, 0, (i == 2), 0, 0);
            checks++;
            if (obs_ready !== e_ready || {issue_valid, issue_unit, rs_full, rob_full} !==
                {e_valid, e_unit, e_rs_full, e_rob_full}) begin
                errors++;
                $display("FAIL lsb c%0d: got r=%b v=%b u=%b want r=%b v=%b u=%b", i,
                         obs_ready, issue_valid, issue_unit, e_ready, e_valid, e_unit);
            end
            if (issue_valid && issue_unit == 3'b010) n++;
        end
        checks++;
        if (n != 9) begin
            errors++; $display("FAIL lsb_issue_count: got %0d want 9", n);
        end
    endtask

    task automatic test_serial();
        logic [4:0] ops [12];
        bit cm [12];
        int wait_low, sys_seen;
        ops = '{5'd1, 5'd2, 5'd28, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd31, 5'd31, 5'd31};
        cm  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        wait_low = 0; sys_seen = 0;
        tick(1'b0, 5'd31, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, ops[i], 0, 0, cm[i], 0);
            checks++;
            if (obs_ready !== e_ready || {issue_valid, issue_unit, rs_full, rob_full} !==
                {e_valid, e_unit, e_rs_full, e_rob_full}) begin
                errors++;
                $display("FAIL serial c%0d: got r=%b v=%b u=%b want r=%b v=%b u=%b", i,
                         obs_ready, issue_valid, issue_unit, e_ready, e_valid, e_unit);
            end
            if (i >= 3 && i <= 7 && obs_ready === 1'b0) wait_low++;
            if (issue_valid && issue_unit == 3'b100 && issue_op == 5'd28) sys_seen++;
        end
        checks++;
        if (wait_low != 5 || sys_seen != 1) begin
            errors++; $display("FAIL serial_wait: got low=%0d sys=%0d want 5/1", wait_low, sys_seen);
        end
    endtask

    task automatic test_flush();
        int first_tag;
        first_tag = -1;
        tick(1'b0, 5'd31, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick(1'b1, (i < 9) ? 5'd7 : 5'd31, 0, 0, 0, 0);
        tick(1'b1, 5'd3, 1, 1, 1, 1);
        checks++;
        if ({issue_valid, rs_full, rob_full} !== 3'b000 || {issue_valid, rs_full} !== {e_valid, e_rs_full}) begin
            errors++;
            $display("FAIL flush_clear: got v=%b rsf=%b robf=%b want 000", issue_valid, rs_full, rob_full);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, (i < 9) ? 5'd9 : 5'd31, 0, 0, 0, 0);
            checks++;
            if (obs_ready !== e_ready || {issue_valid, issue_unit, rs_full, rob_full} !==
                {e_valid, e_unit, e_rs_full, e_rob_full}) begin
                errors++;
                $display("FAIL flush_after c%0d: got r=%b v=%b rsf=%b want r=%b v=%b rsf=%b", i,
                         obs_ready, issue_valid, rs_full, e_ready, e_valid, e_rs_full);
            end
            if (i == 0) begin
                checks++;
                if (obs_ready !== 1'b1 || issue_valid !== 1'b0) begin
                    errors++; $display("FAIL flush_ready: got r=%b v=%b want 1/0", obs_ready, issue_valid);
                end
            end
            if (issue_valid && first_tag < 0) first_tag = int'(issue_tag);
        end
        checks++;
        if (first_tag != 0) begin
            errors++; $display("FAIL flush_tag: got %0d want 0", first_tag);
        end
    endtask

    task automatic test_random();
        tick(1'b0, 5'd31, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0);
            checks++;
            if (obs_ready !== e_ready || {issue_valid, issue_unit, rs_full, rob_full} !==
                {e_valid, e_unit, e_rs_full, e_rob_full}) begin
                errors++;
                $display("FAIL random c%0d: got r=%b v=%b u=%b rsf=%b robf=%b want r=%b v=%b u=%b rsf=%b robf=%b",
                         i, obs_ready, issue_valid, issue_unit, rs_full, rob_full,
                         e_ready, e_valid, e_unit, e_rs_full, e_rob_full);
            end
            if (e_valid) begin
                checks++;
                if ({issue_op, issue_rs1, issue_rs2, issue_rd, issue_imm, issue_has_imm, issue_tag} !==
                    {e_op, e_rs1, e_rs2, e_rd, e_imm, e_hi, e_tag}) begin
                    errors++;
                    $display("FAIL random_fields c%0d: got op=%0d rd=%0d tag=%0d want op=%0d rd=%0d tag=%0d",
                             i, issue_op, issue_rd, issue_tag, e_op, e_rd, e_tag);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; in_op = 5'd31; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_imm = '0; in_has_imm = 1'b0;
        rs_release = 1'b0; lsb_release = 1'b0; rob_commit = 1'b0; flush = 1'b0;
        model_reset();
        test_reset();
        test_alu_burst();
        test_rs_full();
        test_tag_wrap();
        test_lsb_release();
        test_serial();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
